// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, memory-busy freeze, perf counters.
// Latency: control outputs are combinational from state + inputs; counters/FSM update on the next edge.
// Backpressure: dmem_busy freezes the whole pipeline (pc, IF/ID, later stages) until it drops.
module hazard_ctrl_unit #(
  parameter int BR_FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 64,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_uses_rs1,
  input  logic             ifid_uses_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             mem_timeout_err
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'b00,
    S_FLUSH    = 2'b01,
    S_MEM_WAIT = 2'b10,
    S_ILLEGAL  = 2'b11
  } state_t;

  state_t          state;
  state_t          ret_state;   // where MEM_WAIT goes back to (RUN or FLUSH)
  state_t          eff_state;   // state whose rules apply this cycle
  logic [1:0]      fcnt;
  logic [WC_W-1:0] wait_cnt;

  logic load_use;
  logic take_br;     // taken branch accepted this cycle
  logic lu_stall;    // load-use stall applied this cycle
  logic flush_cyc;   // a FLUSH-state cycle consumed this cycle
  logic legal;

  assign state_o = state;
  assign legal   = (state != S_ILLEGAL);

  assign load_use = idex_mem_read && (idex_rd != 5'd0) &&
                    ((ifid_uses_rs1 && (ifid_rs1 == idex_rd)) ||
                     (ifid_uses_rs2 && (ifid_rs2 == idex_rd)));

  // Mealy control outputs; busy wins, then branch, then load-use.
  // When busy drops in MEM_WAIT the saved return state's rules apply this same cycle.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    take_br     = 1'b0;
    lu_stall    = 1'b0;
    flush_cyc   = 1'b0;
    eff_state   = state;
    if (state == S_MEM_WAIT && !dmem_busy) eff_state = ret_state;

    if (legal && dmem_busy) begin
      pipe_hold  = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else begin
      case (eff_state)
        S_RUN: begin
          if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            take_br     = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            lu_stall    = 1'b1;
          end
        end
        S_FLUSH: begin
          // Wrong-path instructions: both squashed, new branches and load-use ignored.
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          flush_cyc   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Saturating performance counters; memory freeze cycles count as stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if ((pipe_hold || lu_stall) && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (take_br && (flush_events != '1))
        flush_events <= flush_events + CNT_W'(1);
    end
  end

  // FSM with flush countdown, memory-wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= S_RUN;
      ret_state       <= S_RUN;
      fcnt            <= 2'd0;
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
    end else if (!legal) begin
      state    <= S_RUN;
      wait_cnt <= '0;
    end else if (dmem_busy) begin
      state <= S_MEM_WAIT;
      if (state != S_MEM_WAIT) begin
        // fcnt stays frozen so an interrupted flush resumes where it left off
        ret_state <= state;
        wait_cnt  <= WC_W'(1);
        if (MEM_TIMEOUT <= 1) mem_timeout_err <= 1'b1;
      end else begin
        if (wait_cnt != WC_W'(MEM_TIMEOUT)) wait_cnt <= wait_cnt + WC_W'(1);
        if (wait_cnt >= WC_W'(MEM_TIMEOUT - 1)) mem_timeout_err <= 1'b1;
      end
    end else begin
      wait_cnt  <= '0;
      ret_state <= S_RUN;
      if (take_br) begin
        if (BR_FLUSH_CYCLES > 1) begin
          state <= S_FLUSH;
          fcnt  <= 2'(BR_FLUSH_CYCLES - 1);
        end else begin
          state <= S_RUN;
        end
      end else if (flush_cyc) begin
        fcnt  <= fcnt - 2'd1;
        state <= (fcnt <= 2'd1) ? S_RUN : S_FLUSH;
      end else begin
        state <= S_RUN;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: two instances share stimulus,
// u_dut0 with defaults (1-cycle flush, 16-bit counters), u_dut1 with 2-cycle flush and 4-bit counters.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic       ifid_uses_rs1, ifid_uses_rs2, idex_mem_read, ex_branch_taken, dmem_busy;

  logic        pc_write0, ifid_write0, ifid_flush0, idex_bubble0, pipe_hold0, err0;
  logic [1:0]  state0;
  logic [15:0] stall0, flush0;
  logic        pc_write1, ifid_write1, ifid_flush1, idex_bubble1, pipe_hold1, err1;
  logic [1:0]  state1;
  logic [3:0]  stall1, flush1;
  logic [4:0]  ctrl0, ctrl1;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt;

  always #5 clk = ~clk;

  assign ctrl0 = {pc_write0, ifid_write0, ifid_flush0, idex_bubble0, pipe_hold0};
  assign ctrl1 = {pc_write1, ifid_write1, ifid_flush1, idex_bubble1, pipe_hold1};

  hazard_ctrl_unit u_dut0 (
    .clk(clk), .reset(reset),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
    .idex_rd(idex_rd), .idex_mem_read(idex_mem_read),
    .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
    .pc_write(pc_write0), .ifid_write(ifid_write0), .ifid_flush(ifid_flush0),
    .idex_bubble(idex_bubble0), .pipe_hold(pipe_hold0), .state_o(state0),
    .stall_cycles(stall0), .flush_events(flush0), .mem_timeout_err(err0)
  );

  hazard_ctrl_unit #(.BR_FLUSH_CYCLES(2), .MEM_TIMEOUT(64), .CNT_W(4)) u_dut1 (
    .clk(clk), .reset(reset),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
    .idex_rd(idex_rd), .idex_mem_read(idex_mem_read),
    .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
    .pc_write(pc_write1), .ifid_write(ifid_write1), .ifid_flush(ifid_flush1),
    .idex_bubble(idex_bubble1), .pipe_hold(pipe_hold1), .state_o(state1),
    .stall_cycles(stall1), .flush_events(flush1), .mem_timeout_err(err1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // move to the falling edge to sample Mealy outputs
  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; idex_rd = 5'd0;
    ifid_uses_rs1 = 1'b0; ifid_uses_rs2 = 1'b0; idex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    idex_mem_read = 1'b1; idex_rd = rd; ifid_rs2 = 5'd5; ifid_uses_rs2 = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    do_reset();

    // reset state
    mid();
    check_val("rst_ctrl0", 32'(ctrl0), 32'b11000);
    check_val("rst_ctrl1", 32'(ctrl1), 32'b11000);
    check_val("rst_state0", 32'(state0), 32'd0);
    check_val("rst_stall0", 32'(stall0), 32'd0);
    check_val("rst_flush0", 32'(flush0), 32'd0);
    check_val("rst_err0", 32'(err0), 32'd0);

    // single load-use cycle
    tick();
    set_load_use(5'd5);
    mid();
    check_val("lu_ctrl0", 32'(ctrl0), 32'b00010);
    tick();
    clear_inputs();
    mid();
    check_val("lu_after_ctrl0", 32'(ctrl0), 32'b11000);
    check_val("lu_stall0", 32'(stall0), 32'd1);
    check_val("lu_stall1", 32'(stall1), 32'd1);

    // rd = x0 never stalls
    set_load_use(5'd0);
    ifid_rs2 = 5'd0;
    mid();
    check_val("x0_ctrl0", 32'(ctrl0), 32'b11000);
    tick();
    clear_inputs();
    check_val("x0_stall0", 32'(stall0), 32'd1);

    // branch + load-use same cycle: flush wins
    do_reset();
    set_load_use(5'd5);
    ex_branch_taken = 1'b1;
    mid();
    check_val("br_lu_ctrl0", 32'(ctrl0), 32'b11110);
    tick();
    clear_inputs();
    check_val("br_lu_flush0", 32'(flush0), 32'd1);
    check_val("br_lu_stall0", 32'(stall0), 32'd0);
    check_val("br_lu_state0", 32'(state0), 32'd0);
    check_val("br_lu_state1", 32'(state1), 32'd1);

    // 2-cycle flush; second taken during FLUSH is ignored by u_dut1
    do_reset();
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      ex_branch_taken = (i < 2);
      mid();
      if (ifid_flush1) cnt++;
      tick();
    end
    clear_inputs();
    check_val("fl2_cycles1", 32'(cnt), 32'd2);
    check_val("fl2_events1", 32'(flush1), 32'd1);
    check_val("fl2_events0", 32'(flush0), 32'd2);
    check_val("fl2_state1", 32'(state1), 32'd0);

    // busy inserted in second flush cycle
    do_reset();
    ex_branch_taken = 1'b1;
    tick();
    ex_branch_taken = 1'b0;
    dmem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      check_val("flb_hold1", 32'(ctrl1), 32'b00001);
      tick();
      if (i == 0) check_val("flb_state1", 32'(state1), 32'd2);
    end
    dmem_busy = 1'b0;
    mid();
    check_val("flb_resume1", 32'(ctrl1), 32'b11110);
    check_val("flb_resume0", 32'(ctrl0), 32'b11000);
    tick();
    mid();
    check_val("flb_done1", 32'(ctrl1), 32'b11000);
    check_val("flb_state1b", 32'(state1), 32'd0);
    check_val("flb_stall1", 32'(stall1), 32'd3);
    check_val("flb_stall0", 32'(stall0), 32'd3);
    check_val("flb_events1", 32'(flush1), 32'd1);

    // long memory wait and sticky timeout
    do_reset();
    dmem_busy = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 70; i++) begin
      mid();
      if (pipe_hold0) cnt++;
      tick();
      if (i == 63) check_val("to_err_63", 32'(err0), 32'd0);
      if (i == 64) check_val("to_err_64", 32'(err0), 32'd1);
    end
    dmem_busy = 1'b0;
    check_val("to_hold_cnt", 32'(cnt), 32'd70);
    mid();
    check_val("to_release0", 32'(ctrl0), 32'b11000);
    tick();
    check_val("to_err_sticky", 32'(err0), 32'd1);
    check_val("to_state0", 32'(state0), 32'd0);
    check_val("to_stall0", 32'(stall0), 32'd70);
    check_val("to_stall1_sat", 32'(stall1), 32'd15);
    do_reset();
    check_val("to_err_cleared", 32'(err0), 32'd0);

    // 2^4+5 load-use stalls saturate the 4-bit counter
    set_load_use(5'd5);
    for (int i = 0; i < 21; i++) tick();
    clear_inputs();
    check_val("sat_stall1", 32'(stall1), 32'd15);
    check_val("sat_stall0", 32'(stall0), 32'd21);
    check_val("sat_flush1", 32'(flush1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
